memory_access_unit: RTL and testbench

//   Multi-cycle load/store sequencer between the execute stage and data memory.
//   - Address comes from ALU_result; store data comes from the register bank memory_output.
//   - Drives the memory request and waits out wait-states.
//   - Returns the aligned, sign/zero-extended load word on data_from_memory, feeding the register bank.
//   - busy is the pipeline stall; done pulses when the bank may write back (control=3).

---
 rtl/memory_access_unit.sv | 181 ++++++++++++++++++
 tb/tb_memory_access_unit.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_access_unit.sv
// Multi-cycle load/store sequencer between the execute stage and data memory.
// Optional ACCESS-state timeout enabled by defining MEM_TIMEOUT_EN.
module memory_access_unit #(
    parameter int unsigned REGISTER_LENGTH = 32,
    parameter int unsigned ADDR_WIDTH      = 32
`ifdef MEM_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES  = 64
`endif
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic [2:0]                 op,
    input  logic [ADDR_WIDTH-1:0]      address,
    input  logic [REGISTER_LENGTH-1:0] store_data,
    output logic [ADDR_WIDTH-3:0]      mem_addr,
    output logic [REGISTER_LENGTH-1:0] mem_wdata,
    output logic [3:0]                 mem_byte_en,
    output logic                       mem_rd_en,
    output logic                       mem_wr_en,
    input  logic [REGISTER_LENGTH-1:0] mem_rdata,
    input  logic                       mem_ready,
    output logic [REGISTER_LENGTH-1:0] data_from_memory,
    output logic                       busy,
    output logic                       done,
    output logic                       load_done,
    output logic                       fault
);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e                     state_q, state_d;
    logic [2:0]                 op_q, op_d;
    logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
    logic [REGISTER_LENGTH-1:0] wdata_q, wdata_d;
    logic [REGISTER_LENGTH-1:0] rdata_q, rdata_d;
    logic [3:0]                 be_q, be_d;
    logic                       fault_q, fault_d;

    logic                       in_word, in_half, in_misaligned;
    logic [3:0]                 in_be;
    logic [REGISTER_LENGTH-1:0] in_wdata;
    logic                       is_load;
    logic [7:0]                 rd_byte;
    logic [15:0]                rd_half;
    logic [REGISTER_LENGTH-1:0] load_ext;
    logic                       timeout;

    // Decode of the request presented with start
    always_comb begin
        in_word  = (op == 3'd0) || (op == 3'd5);
        in_half  = (op == 3'd1) || (op == 3'd2) || (op == 3'd6);
        in_misaligned = (in_word && (address[1:0] != 2'b00)) || (in_half && address[0]);
        if (in_word) begin
            in_be    = 4'b1111;
            in_wdata = store_data;
        end else if (in_half) begin
            in_be    = address[1] ? 4'b1100 : 4'b0011;
            in_wdata = {2{store_data[15:0]}};
        end else begin
            in_be    = 4'b0001 << address[1:0];
            in_wdata = {4{store_data[7:0]}};
        end
    end

    assign is_load = (op_q < 3'd5);

    always_comb begin
        case (addr_q[1:0])
            2'd0:    rd_byte = mem_rdata[7:0];
            2'd1:    rd_byte = mem_rdata[15:8];
            2'd2:    rd_byte = mem_rdata[23:16];
            default: rd_byte = mem_rdata[31:24];
        endcase
        rd_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (op_q)
            3'd1:    load_ext = {{(REGISTER_LENGTH-16){rd_half[15]}}, rd_half};
            3'd2:    load_ext = {{(REGISTER_LENGTH-16){1'b0}}, rd_half};
            3'd3:    load_ext = {{(REGISTER_LENGTH-8){rd_byte[7]}}, rd_byte};
            3'd4:    load_ext = {{(REGISTER_LENGTH-8){1'b0}}, rd_byte};
            default: load_ext = mem_rdata;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] cnt_q, cnt_d;

    // Fires on the ACCESS cycle whose increment would reach the limit
    assign timeout = !mem_ready && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == StIdle) begin
            cnt_d = '0;
        end else if (state_q == StAccess && !mem_ready) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        fault_d = fault_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    op_d    = op;
                    addr_d  = address;
                    wdata_d = in_wdata;
                    be_d    = in_be;
                    fault_d = in_misaligned;
                    state_d = in_misaligned ? StDone : StAccess;
                end
            end
            StAccess: begin
                // mem_ready beats a coincident timeout
                if (mem_ready) begin
                    state_d = StDone;
                    fault_d = 1'b0;
                    if (is_load) begin
                        rdata_d = load_ext;
                    end
                end else if (timeout) begin
                    state_d = StDone;
                    fault_d = 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end

    assign mem_addr         = addr_q[ADDR_WIDTH-1:2];
    assign mem_wdata        = wdata_q;
    assign mem_byte_en      = be_q;
    assign mem_rd_en        = (state_q == StAccess) && is_load;
    assign mem_wr_en        = (state_q == StAccess) && !is_load;
    assign data_from_memory = rdata_q;
    assign busy             = (state_q != StIdle);
    assign done             = (state_q == StDone);
    assign fault            = done && fault_q;
    assign load_done        = done && is_load && !fault_q;

endmodule

// File: tb/tb_memory_access_unit.sv
// Scoreboard bench for memory_access_unit; covers the MEM_TIMEOUT_EN build when the macro is set.
module tb_memory_access_unit;

    localparam int TO = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] address;
    logic [31:0] store_data;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_en;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [31:0] data_from_memory;
    logic        busy;
    logic        done;
    logic        load_done;
    logic        fault;

    int checks   = 0;
    int failures = 0;
    logic [31:0] model_data = 32'h0;

    typedef struct {
        logic [31:0] data;
        logic        fault;
        logic        ld;
        int          lat;
        int          strobes;
    } exp_t;
    exp_t sb[$];

    memory_access_unit #(
        .REGISTER_LENGTH(32),
        .ADDR_WIDTH     (32)
`ifdef MEM_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (TO)
`endif
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .op              (op),
        .address         (address),
        .store_data      (store_data),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_byte_en     (mem_byte_en),
        .mem_rd_en       (mem_rd_en),
        .mem_wr_en       (mem_wr_en),
        .mem_rdata       (mem_rdata),
        .mem_ready       (mem_ready),
        .data_from_memory(data_from_memory),
        .busy            (busy),
        .done            (done),
        .load_done       (load_done),
        .fault           (fault)
    );

    always #5 clock = ~clock;

    function automatic bit m_mis(input logic [2:0] o, input logic [31:0] a);
        if (o == 3'd0 || o == 3'd5) return a[1:0] != 2'b00;
        if (o == 3'd1 || o == 3'd2 || o == 3'd6) return a[0];
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_ext(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(rd >> (8 * a[1:0]));
        h = a[1] ? rd[31:16] : rd[15:0];
        case (o)
            3'd1:    return {{16{h[15]}}, h};
            3'd2:    return {16'h0, h};
            3'd3:    return {{24{b[7]}}, b};
            3'd4:    return {24'h0, b};
            default: return rd;
        endcase
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] o, input logic [31:0] a);
        case (o)
            3'd0, 3'd5:       return 4'hF;
            3'd1, 3'd2, 3'd6: return a[1] ? 4'hC : 4'h3;
            default:          return 4'(1 << a[1:0]);
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] o, input logic [31:0] sd);
        case (o)
            3'd5:    return sd;
            3'd6:    return {sd[15:0], sd[15:0]};
            default: return {sd[7:0], sd[7:0], sd[7:0], sd[7:0]};
        endcase
    endfunction

    // One transaction; poke drives stray starts during ACCESS (cycle 2) and the DONE cycle.
    task automatic run_txn(input logic [2:0] o, input logic [31:0] a, input logic [31:0] sd,
                           input logic [31:0] rd, input int waits, input bit poke);
        exp_t e;
        exp_t got;
        int   cyc;
        int   acc;
        int   strobes;
        bit   is_ld;
        is_ld     = (o < 3'd5);
        e.fault   = m_mis(o, a);
        e.data    = model_data;
        e.ld      = 1'b0;
        e.lat     = 1;
        e.strobes = 0;
        if (!e.fault) begin
`ifdef MEM_TIMEOUT_EN
            if (waits >= TO) begin
                e.fault   = 1'b1;
                e.lat     = 1 + TO;
                e.strobes = TO;
            end else
`endif
            begin
                e.lat     = 2 + waits;
                e.strobes = waits + 1;
                e.ld      = is_ld;
                if (is_ld) e.data = m_ext(o, a, rd);
            end
        end
        model_data = e.data;
        sb.push_back(e);

        op = o; address = a; store_data = sd; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0; op = ~o; address = ~a; store_data = ~sd;
        cyc = 1; acc = 0; strobes = 0;
        while (!done && cyc < 200) begin
            if (mem_rd_en || mem_wr_en) begin
                strobes++;
                checks++;
                if (mem_rd_en !== is_ld || mem_wr_en !== !is_ld || mem_addr !== a[31:2]
                    || busy !== 1'b1) begin
                    failures++;
                    $display("FAIL strobe op=%0d cyc=%0d: rd=%b wr=%b addr=%h busy=%b, want addr=%h",
                             o, cyc, mem_rd_en, mem_wr_en, mem_addr, busy, a[31:2]);
                end
                if (!is_ld) begin
                    checks++;
                    if (mem_byte_en !== m_be(o, a) || mem_wdata !== m_wdata(o, sd)) begin
                        failures++;
                        $display("FAIL store_lanes op=%0d cyc=%0d: be=%b wdata=%h, want be=%b wdata=%h",
                                 o, cyc, mem_byte_en, mem_wdata, m_be(o, a), m_wdata(o, sd));
                    end
                end
                mem_rdata = rd;
                mem_ready = (acc == waits);
                acc++;
            end else begin
                mem_ready = 1'b0;
            end
            if (poke && cyc == 2) begin
                start = 1'b1; op = 3'd5; address = 32'h40;
            end else if (poke && cyc == 3) begin
                start = 1'b0;
            end
            @(posedge clock); #1;
            cyc++;
        end
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        start     = 1'b0;
        got = sb.pop_front();
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL done_timeout op=%0d addr=%h: no done within %0d cycles", o, a, cyc);
            return;
        end
        if (data_from_memory !== got.data || fault !== got.fault || load_done !== got.ld
            || cyc != got.lat || strobes != got.strobes || busy !== 1'b1) begin
            failures++;
            $display("FAIL result op=%0d addr=%h: data=%h fault=%b ld=%b lat=%0d strobes=%0d busy=%b, want data=%h fault=%b ld=%b lat=%0d strobes=%0d",
                     o, a, data_from_memory, fault, load_done, cyc, strobes, busy,
                     got.data, got.fault, got.ld, got.lat, got.strobes);
        end
        if (poke) begin
            start = 1'b1; op = 3'd0; address = 32'h100;
        end
        @(posedge clock); #1;
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL after_done op=%0d: done=%b busy=%b, want 0 0", o, done, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = 3'd0; address = 32'h0; store_data = 32'h0;
        mem_rdata = 32'h0; mem_ready = 1'b0;
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({mem_addr, mem_wdata, mem_byte_en, mem_rd_en, mem_wr_en, data_from_memory,
             busy, done, load_done, fault} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: busy=%b done=%b data=%h addr=%h, want all 0",
                     busy, done, data_from_memory, mem_addr);
        end
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_load_word();
        run_txn(3'd0, 32'h0000_2000, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);
        run_txn(3'd0, 32'h0000_2004, 32'h0, 32'h1357_9BDF, 2, 1'b0);
    endtask

    task automatic test_load_extend();
        run_txn(3'd3, 32'h0000_2003, 32'h0, 32'h80FF_1234, 0, 1'b0);
        run_txn(3'd4, 32'h0000_2003, 32'h0, 32'h80FF_1234, 0, 1'b0);
        run_txn(3'd1, 32'h0000_2002, 32'h0, 32'h80FF_1234, 1, 1'b0);
        run_txn(3'd2, 32'h0000_2002, 32'h0, 32'h80FF_1234, 0, 1'b0);
        run_txn(3'd3, 32'h0000_2001, 32'h0, 32'h80FF_1234, 0, 1'b0);
        run_txn(3'd1, 32'h0000_2000, 32'h0, 32'h80FF_9234, 0, 1'b0);
    endtask

    task automatic test_store();
        run_txn(3'd6, 32'h0000_2002, 32'h0000_ABCD, 32'hFFFF_FFFF, 3, 1'b0);
        run_txn(3'd7, 32'h0000_2001, 32'h1234_5655, 32'h0, 0, 1'b0);
        run_txn(3'd5, 32'h0000_2004, 32'hCAFE_F00D, 32'h0, 1, 1'b0);
        run_txn(3'd6, 32'h0000_2000, 32'h9876_5432, 32'h0, 0, 1'b0);
    endtask

    task automatic test_misaligned();
        run_txn(3'd0, 32'h0000_2001, 32'h0, 32'h1111_1111, 0, 1'b1);
        run_txn(3'd6, 32'h0000_2003, 32'h5555, 32'h0, 0, 1'b0);
        run_txn(3'd2, 32'h0000_2005, 32'h0, 32'h2222_2222, 0, 1'b0);
        run_txn(3'd0, 32'h0000_2010, 32'h0, 32'hA5A5_0F0F, 3, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            run_txn(3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                    int'($urandom_range(0, 3)), 1'b0);
        end
    endtask

    task automatic test_timeout();
`ifdef MEM_TIMEOUT_EN
        run_txn(3'd0, 32'h0000_3000, 32'h0, 32'h7777_7777, 1000, 1'b0);
        run_txn(3'd0, 32'h0000_3004, 32'h0, 32'h6666_6666, TO - 1, 1'b0);
`else
        op = 3'd0; address = 32'h0000_3000; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clock); #1;
        end
        checks++;
        if (busy !== 1'b1 || mem_rd_en !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL no_timeout_hang: busy=%b rd=%b done=%b, want 1 1 0",
                     busy, mem_rd_en, done);
        end
`endif
    endtask

    task automatic test_async_reset();
        if (!busy) begin
            op = 3'd0; address = 32'h0000_3008; start = 1'b1;
            @(posedge clock); #1;
            start = 1'b0;
            @(posedge clock); #1;
        end
        #3 reset = 1'b0;
        #1;
        checks++;
        if ({mem_addr, mem_wdata, mem_byte_en, mem_rd_en, mem_wr_en, data_from_memory,
             busy, done, load_done, fault} !== '0) begin
            failures++;
            $display("FAIL async_reset: busy=%b rd=%b done=%b data=%h, want all 0",
                     busy, mem_rd_en, done, data_from_memory);
        end
        model_data = 32'h0;
        #2 reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL post_reset cyc=%0d: done=%b busy=%b, want 0 0", i, done, busy);
            end
        end
        run_txn(3'd4, 32'h0000_2002, 32'h0, 32'h00C3_0000, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_load_extend();
        test_store();
        test_misaligned();
        test_back_to_back();
        test_timeout();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
